// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: line-aligned fetch requests, in-order response forwarding,
// redirect handling with stale-response discard. Optional perf counters under FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     BUS_LEN  = 2,
    parameter int unsigned     MAX_OUT  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int unsigned    BUS_WID  = BUS_LEN * 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redir_vld,
    input  logic [XLEN-1:0]    redir_pc,
    input  logic               buffer_free,
    output logic               jump_vld,
    output logic [XLEN-1:0]    jump_pc,
    output logic               line_vld,
    output logic [BUS_WID-1:0] line_data,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvld,
    input  logic [BUS_WID-1:0] imem_rdata
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_drop
`endif
);

    localparam int unsigned     LB        = BUS_LEN * 4;
    localparam int unsigned     CNT_W     = $clog2(MAX_OUT + 1);
    localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(LB - 1);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [XLEN-1:0]    fetch_addr_q, fetch_addr_d;
    logic [CNT_W-1:0]   out_q, out_d, out_dec;
    logic [CNT_W-1:0]   disc_q, disc_d;
    logic               jump_vld_d;
    logic [XLEN-1:0]    jump_pc_d;
    logic               line_vld_d;
    logic [BUS_WID-1:0] line_data_d;
    logic               run, redir, grant, rsp, drop;

    // Request qualification; a redirect cycle never issues so no new stale requests appear
    assign run       = (state_q == ST_RUN);
    assign redir     = run & redir_vld;
    assign imem_req  = run & fetch_en & buffer_free & (out_q < CNT_W'(MAX_OUT)) & ~redir_vld;
    assign imem_addr = fetch_addr_q;
    assign grant     = imem_req & imem_gnt;

    // An rvld with nothing outstanding is a protocol error and is ignored
    assign rsp     = imem_rvld & (out_q != '0);
    assign out_dec = out_q - CNT_W'(rsp);
    assign drop    = rsp & (redir | (disc_q != '0));

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        out_d        = out_dec + CNT_W'(grant);
        disc_d       = disc_q;
        jump_vld_d   = 1'b0;
        jump_pc_d    = jump_pc;
        line_vld_d   = 1'b0;
        line_data_d  = line_data;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                jump_vld_d = 1'b1;
                jump_pc_d  = RESET_PC;
            end
            default: begin
                if (rsp && !drop) begin
                    line_vld_d  = 1'b1;
                    line_data_d = imem_rdata;
                end
                if (redir) begin
                    jump_vld_d   = 1'b1;
                    jump_pc_d    = redir_pc;
                    fetch_addr_d = redir_pc & LINE_MASK;
                    disc_d       = out_dec;
                end else begin
                    if (rsp && (disc_q != '0)) begin
                        disc_d = disc_q - CNT_W'(1);
                    end
                    if (grant) begin
                        fetch_addr_d = fetch_addr_q + XLEN'(LB);
                    end
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            fetch_addr_q <= RESET_PC & LINE_MASK;
            out_q        <= '0;
            disc_q       <= '0;
            jump_vld     <= 1'b0;
            jump_pc      <= '0;
            line_vld     <= 1'b0;
            line_data    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            out_q        <= out_d;
            disc_q       <= disc_d;
            jump_vld     <= jump_vld_d;
            jump_pc      <= jump_pc_d;
            line_vld     <= line_vld_d;
            line_data    <= line_data_d;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    // Free-running event counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_drop  <= '0;
        end else begin
            if (run && fetch_en && !buffer_free) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (drop) begin
                perf_drop <= perf_drop + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboarded lines/jumps/grants against an
// epoch-tagged memory model; perf counters checked when FETCH_SEQ_PERF_EN is defined.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        buffer_free;
    logic        jump_vld;
    logic [31:0] jump_pc;
    logic        line_vld;
    logic [63:0] line_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvld;
    logic [63:0] imem_rdata;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_drop;
`endif

    fetch_sequencer #(
        .XLEN(32), .BUS_LEN(2), .MAX_OUT(2), .RESET_PC(32'h84)
    ) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redir_vld(redir_vld),
        .redir_pc(redir_pc), .buffer_free(buffer_free), .jump_vld(jump_vld),
        .jump_pc(jump_pc), .line_vld(line_vld), .line_data(line_data),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvld(imem_rvld), .imem_rdata(imem_rdata)
`ifdef FETCH_SEQ_PERF_EN
        , .perf_stall(perf_stall), .perf_drop(perf_drop)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          tag;
    } req_t;

    req_t        pend[$];
    logic [63:0] exp_line[$];
    logic [31:0] exp_jump[$];
    logic [31:0] exp_addr[$];

    int errors = 0;
    int checks = 0;
    int epoch = 0;
    int cur_tag = 0;
    int model_drops = 0;
    int lines_seen = 0;
    logic auto_gnt = 1'b0;
    logic auto_rsp = 1'b0;

    function automatic logic [63:0] mk(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // One clock cycle: model the memory, score grants before the edge, lines/jumps after it
    task automatic tick();
        bit          line_exp;
        bit          jump_exp;
        logic [31:0] ea;
        logic [63:0] el;
        req_t        r;
        #1;
        line_exp = 0;
        jump_exp = 0;
        if (imem_rvld) begin
            if (redir_vld || cur_tag != epoch) model_drops++;
            else begin
                exp_line.push_back(imem_rdata);
                line_exp = 1;
            end
        end
        if (redir_vld) begin
            exp_jump.push_back(redir_pc);
            jump_exp = 1;
            epoch++;
        end
        imem_gnt = auto_gnt;
        if (imem_req && imem_gnt) begin
            pend.push_back('{imem_addr, epoch});
            if (exp_addr.size() > 0) begin
                ea = exp_addr.pop_front();
                checks++;
                if (imem_addr !== ea) begin
                    errors++;
                    $display("FAIL grant_addr: got %h expected %h", imem_addr, ea);
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (line_vld !== line_exp) begin
            errors++;
            $display("FAIL line_vld: got %b expected %b", line_vld, line_exp);
        end
        if (line_vld && line_exp) begin
            el = exp_line.pop_front();
            lines_seen++;
            checks++;
            if (line_data !== el) begin
                errors++;
                $display("FAIL line_data: got %h expected %h", line_data, el);
            end
        end
        checks++;
        if (jump_vld !== jump_exp) begin
            errors++;
            $display("FAIL jump_vld: got %b expected %b", jump_vld, jump_exp);
        end
        if (jump_vld && jump_exp) begin
            ea = exp_jump.pop_front();
            checks++;
            if (jump_pc !== ea) begin
                errors++;
                $display("FAIL jump_pc: got %h expected %h", jump_pc, ea);
            end
        end
        if (auto_rsp && pend.size() > 0) begin
            r          = pend.pop_front();
            imem_rvld  = 1'b1;
            imem_rdata = mk(r.addr);
            cur_tag    = r.tag;
        end else begin
            imem_rvld  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_en = 1'b1; buffer_free = 1'b1; redir_vld = 1'b0;
        redir_pc = '0; imem_gnt = 1'b0; imem_rvld = 1'b0; imem_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (jump_vld !== 1'b0) begin errors++; $display("FAIL reset_jump_vld: got %b expected 0", jump_vld); end
        checks++; if (jump_pc !== 32'h0) begin errors++; $display("FAIL reset_jump_pc: got %h expected 0", jump_pc); end
        checks++; if (line_vld !== 1'b0) begin errors++; $display("FAIL reset_line_vld: got %b expected 0", line_vld); end
        checks++; if (line_data !== 64'h0) begin errors++; $display("FAIL reset_line_data: got %h expected 0", line_data); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b expected 0", imem_req); end
    endtask

    task automatic test_boot();
        @(posedge clk); #1;
        fetch_en = 1'b1; buffer_free = 1'b1; redir_vld = 1'b0; imem_gnt = 1'b0; imem_rvld = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req_in_boot: got %b expected 0", imem_req); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (jump_vld !== 1'b1) begin errors++; $display("FAIL boot_jump_vld: got %b expected 1", jump_vld); end
        checks++; if (jump_pc !== 32'h84) begin errors++; $display("FAIL boot_jump_pc: got %h expected 00000084", jump_pc); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL boot_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL boot_addr: got %h expected 00000080", imem_addr); end
    endtask

    task automatic test_streaming(input int n);
        int base;
        base = lines_seen;
        auto_gnt = 1'b1; auto_rsp = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < n; i++) exp_addr.push_back(32'h80 + 32'(8 * i));
        for (int i = 0; i < n; i++) tick();
        fetch_en = 1'b0;
        tick(); tick();
        checks++; if (lines_seen - base !== n) begin errors++; $display("FAIL stream_lines: got %0d expected %0d", lines_seen - base, n); end
        checks++; if (exp_addr.size() !== 0) begin errors++; $display("FAIL stream_grants_left: got %0d expected 0", exp_addr.size()); end
    endtask

    task automatic test_backpressure();
`ifdef FETCH_SEQ_PERF_EN
        logic [31:0] s0;
        s0 = perf_stall;
`endif
        fetch_en = 1'b1; buffer_free = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", imem_req); end
            checks++; if (imem_addr !== 32'h98) begin errors++; $display("FAIL bp_addr: got %h expected 00000098", imem_addr); end
            tick();
        end
`ifdef FETCH_SEQ_PERF_EN
        checks++; if (perf_stall - s0 !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", perf_stall - s0); end
`endif
        buffer_free = 1'b1;
        exp_addr.push_back(32'h98);
        tick();
        fetch_en = 1'b0;
        tick(); tick();
        checks++; if (exp_addr.size() !== 0) begin errors++; $display("FAIL bp_grants_left: got %0d expected 0", exp_addr.size()); end
    endtask

    task automatic test_redirect();
        int base;
`ifdef FETCH_SEQ_PERF_EN
        logic [31:0] d0;
        d0 = perf_drop;
`endif
        base = lines_seen;
        auto_rsp = 1'b0; fetch_en = 1'b1;
        exp_addr.push_back(32'hA0);
        tick();
        fetch_en = 1'b0; redir_vld = 1'b1; redir_pc = 32'h106;
        tick();
        redir_vld = 1'b0; fetch_en = 1'b1; auto_rsp = 1'b1;
        exp_addr.push_back(32'h100);
        tick();
        fetch_en = 1'b0;
        tick(); tick(); tick();
        checks++; if (lines_seen - base !== 1) begin errors++; $display("FAIL redir_lines: got %0d expected 1", lines_seen - base); end
        checks++; if (exp_addr.size() !== 0) begin errors++; $display("FAIL redir_grants_left: got %0d expected 0", exp_addr.size()); end
`ifdef FETCH_SEQ_PERF_EN
        checks++; if (perf_drop - d0 !== 32'd1) begin errors++; $display("FAIL perf_drop_redir: got %0d expected 1", perf_drop - d0); end
`endif
    endtask

    task automatic test_redir_rvld();
        int base;
`ifdef FETCH_SEQ_PERF_EN
        logic [31:0] d0;
        d0 = perf_drop;
`endif
        base = lines_seen;
        auto_rsp = 1'b1; fetch_en = 1'b1;
        exp_addr.push_back(32'h108);
        tick();
        fetch_en = 1'b0; redir_vld = 1'b1; redir_pc = 32'h200;
        tick();
        redir_vld = 1'b0; fetch_en = 1'b1;
        exp_addr.push_back(32'h200);
        tick();
        fetch_en = 1'b0;
        tick(); tick();
        checks++; if (lines_seen - base !== 1) begin errors++; $display("FAIL redir_rvld_lines: got %0d expected 1", lines_seen - base); end
        checks++; if (exp_addr.size() !== 0) begin errors++; $display("FAIL redir_rvld_grants_left: got %0d expected 0", exp_addr.size()); end
`ifdef FETCH_SEQ_PERF_EN
        checks++; if (perf_drop - d0 !== 32'd1) begin errors++; $display("FAIL perf_drop_same_cycle: got %0d expected 1", perf_drop - d0); end
        checks++; if (perf_drop !== 32'(model_drops)) begin errors++; $display("FAIL perf_drop_total: got %0d expected %0d", perf_drop, model_drops); end
`endif
    endtask

    task automatic test_async_reset();
        auto_rsp = 1'b0; fetch_en = 1'b1;
        exp_addr.push_back(32'h208);
        exp_addr.push_back(32'h210);
        tick(); tick();
        checks++; if (line_data === 64'h0) begin errors++; $display("FAIL pre_reset_line_data: got %h expected nonzero", line_data); end
        #3;
        rst = 1'b0;
        #1;
        checks++; if (jump_vld !== 1'b0) begin errors++; $display("FAIL areset_jump_vld: got %b expected 0", jump_vld); end
        checks++; if (jump_pc !== 32'h0) begin errors++; $display("FAIL areset_jump_pc: got %h expected 0", jump_pc); end
        checks++; if (line_vld !== 1'b0) begin errors++; $display("FAIL areset_line_vld: got %b expected 0", line_vld); end
        checks++; if (line_data !== 64'h0) begin errors++; $display("FAIL areset_line_data: got %h expected 0", line_data); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL areset_imem_req: got %b expected 0", imem_req); end
`ifdef FETCH_SEQ_PERF_EN
        checks++; if (perf_stall !== 32'h0) begin errors++; $display("FAIL areset_perf_stall: got %0d expected 0", perf_stall); end
        checks++; if (perf_drop !== 32'h0) begin errors++; $display("FAIL areset_perf_drop: got %0d expected 0", perf_drop); end
`endif
        checks++; if (exp_addr.size() !== 0) begin errors++; $display("FAIL areset_grants_left: got %0d expected 0", exp_addr.size()); end
        pend.delete();
        exp_line.delete();
        exp_jump.delete();
        fetch_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_streaming(3);
        test_backpressure();
        test_redirect();
        test_redir_rvld();
        test_async_reset();
        test_boot();
        test_streaming(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller sequencing the instruction line buffer: issues line-aligned fetch requests to instruction memory and throttles on the buffer's `buffer_free`.
- Forwards returned lines as `line_vld`/`line_data`, and converts redirects into a buffer `jump_vld`/`jump_pc`.
- Discards responses made stale by a redirect, and generates the boot redirect after reset.
- Sits between the branch/schedule redirect source, the instruction memory port and the line buffer.

Parameters:
- XLEN, 32, address/instruction width.
- BUS_LEN, 2, 32-bit words per fetch line; line width BUS_WID = BUS_LEN*32; line bytes LB = BUS_LEN*4.
- MAX_OUT, 1, maximum in-flight memory requests (1..4). Values >1 require a buffer with MAX_OUT lines of slack beyond its `buffer_free` threshold.
- RESET_PC, 32'h0, boot address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_en  in  1  permit new requests; 0 = drain only.
- redir_vld  in  1  redirect request from branch/schedule.
- redir_pc  in  XLEN  redirect target, halfword aligned.
- buffer_free  in  1  line buffer can accept one more line.
- jump_vld  out  1  redirect to line buffer.
- jump_pc  out  XLEN  redirect target to line buffer.
- line_vld  out  1  valid line to buffer.
- line_data  out  BUS_WID  line payload.
- imem_req  out  1  memory request.
- imem_addr  out  XLEN  line-aligned request address (low log2(LB) bits zero).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvld  in  1  response valid; responses return in request order.
- imem_rdata  in  BUS_WID  response line.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=BOOT; fetch_addr = RESET_PC & ~(LB-1); outstanding=0; discard=0.
  - jump_vld=0, jump_pc=0, line_vld=0, line_data=0.
  - imem_req=0 (combinational, forced 0 in BOOT).
- States:
  - BOOT: first clock edge after rst deasserts → RUN; registers jump_vld=1, jump_pc=RESET_PC.
  - RUN: normal operation; never left except by reset.
- Request (combinational): imem_req = RUN & fetch_en & buffer_free & (outstanding<MAX_OUT) & ~redir_vld.
  - imem_addr = fetch_addr.
  - req&gnt: fetch_addr += LB (wraps modulo 2^XLEN); outstanding++.
  - An ungranted request may drop when a qualifier falls; the address is retained.
- Response, registered, 1-cycle latency:
  - imem_rvld: outstanding--.
  - If discard>0: discard--, line_vld next cycle = 0.
  - Else: line_vld=1, line_data=imem_rdata next cycle.
  - line_vld is a single-cycle pulse per accepted line.
  - Same-cycle gnt and rvld: outstanding unchanged.
- Redirect (redir_vld=1 in RUN):
  - Next cycle: jump_vld=1, jump_pc=redir_pc. jump_vld is a single-cycle pulse.
  - fetch_addr <= redir_pc & ~(LB-1).
  - discard <= outstanding (value after this cycle's rvld decrement).
  - A response arriving in the redirect cycle is always dropped.
  - line_vld forced 0 in the cycle jump_vld=1; the buffer never sees both together.
  - imem_req=0 in the redirect cycle; no grant is possible, so no new stale requests.
  - Requests may resume the cycle after the redirect even while discard>0, because responses return in order.
  - Back-to-back redirects: last one wins; discard recomputed each time.
- Width rules:
  - outstanding/discard width = clog2(MAX_OUT+1).
  - Underflow/overflow unreachable under the handshake rules; an rvld with outstanding=0 is a protocol error, and is ignored (no decrement, no line).
- fetch_en=0: in-flight responses still delivered; no new requests.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- Defined, adds ports:
  - perf_stall  out  32: counts RUN cycles with fetch_en=1 and imem_req=0 due to buffer_free=0.
  - perf_drop  out  32: counts discarded responses.
  - Both counters reset to 0, wrap at 2^32, never cleared except by reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Boot: RESET_PC=32'h84, BUS_LEN=2; release rst → next cycle jump_vld=1, jump_pc=32'h84; following cycle imem_req=1, imem_addr=32'h80.
- Streaming, MAX_OUT=2, gnt always 1, rvld 1 cycle after gnt with data D0,D1,D2 → addrs 0x80,0x88,0x90; line_vld pulses carrying D0,D1,D2, each 1 cycle after its rvld.
- Backpressure: buffer_free=0 for 5 cycles → imem_req=0 those cycles, addr held; perf_stall +5 with FETCH_SEQ_PERF_EN.
- Redirect with 1 outstanding: redir_pc=32'h106 → jump_vld/jump_pc=32'h106 next cycle; next imem_addr=32'h100; first rvld dropped (line_vld=0, perf_drop=1); second rvld delivered.
- Simultaneous redir_vld+imem_rvld, outstanding=1 → response dropped, discard=0, no line_vld in jump cycle, next response delivered.
- Async reset mid-stream (outstanding=2) → all outputs 0 immediately without a clock edge; boot sequence repeats after release.
